// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store replication, load extraction and alignment check
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  bytesel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] sh;
  assign sh = word >> {offset, 3'b000};
  assign bytesel = funct3[1:0] == 2'd0 ? 4'b0001 << offset :
                   funct3[1:0] == 2'd1 ? 4'b0011 << offset : 4'b1111;
  assign wdata_rep = funct3[1:0] == 2'd0 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                 funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3 == F3_BU ? {24'b0, sh[7:0]} :
                 funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  assign misaligned = (funct3[1:0] == 2'd1 && offset[0]) || (funct3[1:0] == 2'd2 && offset != 2'd0);
endmodule

// File: rtl/lsu_align.sv
// lsu_align: CU load/store request to word-aligned MMU access with fixed-latency response
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        soc_clk,
  input  logic        soc_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] CU_address,
  output logic [3:0]  CU_bytesel,
  output logic [31:0] CU_dat_in,
  output logic        read_or_write,
  output logic        retrieve,
  input  logic [31:0] MMU_dat_out
);
  lsu_state_t state, nxt;
  logic [3:0]  cnt, be_q, be;
  logic [31:0] addr_q, din_q, rdata_q, rep, ext;
  logic        rw_q, st_q, fault_q, mis, illegal, fault, idle;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  assign idle = state == IDLE;
  // lane logic sees the live request while idle, the held request afterwards
  lsu_lane_align u_lane (
    .funct3    (idle ? req_funct3 : f3_q),
    .offset    (idle ? req_addr[1:0] : off_q),
    .wdata     (req_wdata),
    .word      (MMU_dat_out),
    .bytesel   (be),
    .wdata_rep (rep),
    .rdata     (ext),
    .misaligned(mis)
  );
  assign illegal = req_is_store ? req_funct3 >= 3'd3 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  assign fault = mis | illegal;
  always_comb begin
    nxt = state == IDLE  ? (req_valid ? (fault ? RESP : ISSUE) : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge soc_clk) begin
    if (soc_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (idle && req_valid) begin
        addr_q  <= fault ? '0 : {req_addr[31:2], 2'b00};
        be_q    <= fault ? '0 : be;
        din_q   <= (fault || !req_is_store) ? '0 : rep;
        rw_q    <= !fault && req_is_store;
        st_q    <= req_is_store;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        fault_q <= fault;
        rdata_q <= '0;
      end
      if (state == ISSUE) cnt <= 4'(MEM_LATENCY - 1);
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0 && !st_q) rdata_q <= ext;
      end
      if (state == RESP) begin
        addr_q <= '0;
        be_q   <= '0;
        din_q  <= '0;
        rw_q   <= 1'b0;
      end
    end
  end
  assign req_ready     = !soc_rst && idle;
  assign retrieve      = !soc_rst && state == ISSUE;
  assign rsp_valid     = !soc_rst && state == RESP;
  assign rsp_rdata     = rsp_valid ? rdata_q : '0;
  assign rsp_fault     = rsp_valid && fault_q;
  assign CU_address    = soc_rst ? '0 : addr_q;
  assign CU_bytesel    = soc_rst ? '0 : be_q;
  assign CU_dat_in     = soc_rst ? '0 : din_q;
  assign read_or_write = !soc_rst && rw_q;
endmodule
